// File: rtl/x_uart_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and baud divider helpers.
package x_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_W = 8;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/x_uart_tx_buf_if.sv
// Byte handshake into the buffered UART transmitter.
interface x_uart_tx_buf_if;
  import x_uart_pkg::*;

  logic [UART_DATA_W-1:0] i_data;
  logic                   i_valid;
  logic                   o_accept;

  modport master (output i_data, output i_valid, input o_accept);
  modport slave  (input i_data, input i_valid, output o_accept);

endinterface

// File: rtl/x_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; head data is visible whenever not empty.
module x_fifo #(
  parameter int p_width = 8,
  parameter int p_depth = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [p_width-1:0]       i_wdata,
  input  logic                     i_pop,
  output logic [p_width-1:0]       o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(p_depth):0] o_level
);

  localparam int AW = $clog2(p_depth);

  logic [p_width-1:0] mem_q [p_depth];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               do_push_s, do_pop_s;

  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_level   = wr_ptr_q - rd_ptr_q;
  assign o_rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push_s = i_push & ~o_full;
  assign do_pop_s  = i_pop & ~o_empty;

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/x_uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes queue in an x_fifo and are serialised back-to-back on o_tx.
module x_uart_tx_buf
  import x_uart_pkg::*;
#(
  parameter int p_clk_hz = 50000000,
  parameter int p_baud   = 115200,
  parameter int p_depth  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  x_uart_tx_buf_if.slave           bus,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(p_depth):0] o_level
);

  localparam int DIV = baud_div(p_clk_hz, p_baud);
  localparam int BW  = cnt_w(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_tx_state_t         state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic                   accept_s, push_s, pop_s, bit_end_s;
  logic                   full_s, empty_s;
  logic [UART_DATA_W-1:0] head_s;

  assign accept_s     = ~full_s & ~i_rst;
  assign push_s       = bus.i_valid & accept_s;
  assign bus.o_accept = accept_s;
  assign bit_end_s    = (baud_q == BAUD_LAST);
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;

  x_fifo #(
    .p_width (UART_DATA_W),
    .p_depth (p_depth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_s),
    .i_wdata (bus.i_data),
    .i_pop   (pop_s),
    .o_rdata (head_s),
    .o_full  (full_s),
    .o_empty (empty_s),
    .o_level (o_level)
  );

  // Frame sequencing, baud/bit counting and shifting; the FIFO head is popped on entry to START.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = START;
          pop_s   = 1'b1;
          sh_d    = head_s;
          baud_d  = {BW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = {BW{1'b0}};
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_d = {BW{1'b0}};
          sh_d   = {1'b0, sh_q[UART_DATA_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_d = {BW{1'b0}};
          // Chain straight into the next frame so buffered bytes leave without idle gaps.
          if (!empty_s) begin
            state_d = START;
            pop_s   = 1'b1;
            sh_d    = head_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the next state so o_tx is a clean flop output aligned with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Transmitter state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      sh_q    <= {UART_DATA_W{1'b0}};
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule
